taxi_eth_tx_tag_mgr: RTL and testbench

TAXI_ETH_TX_TAG_MGR -- requirements
Module: taxi_eth_tx_tag_mgr

---
 rtl/taxi_eth_tx_tag_mgr_pkg.sv | 22 ++
 rtl/taxi_eth_tx_tag_mgr_prio_enc.sv | 42 ++++
 rtl/taxi_eth_tx_tag_mgr.sv | 184 ++++++++++++++++++
 tb/tb_taxi_eth_tx_tag_mgr.sv | 329 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/taxi_eth_tx_tag_mgr_pkg.sv
// ----------------------------------------------------------------------------
// taxi_eth_tx_tag_mgr_pkg
//
// Purpose:
//   Shared types for the Ethernet TX tag manager. The block widths come from
//   module parameters, so this package only holds the classification of an
//   incoming MAC completion. The top level decodes that classification once
//   and uses it in several places.
//
// Contents:
//   cpl_kind_e - result of looking up an accepted completion in the tag
//                bitmap (nothing accepted / live tag / unallocated tag).
// ----------------------------------------------------------------------------
package taxi_eth_tx_tag_mgr_pkg;

    typedef enum logic [1:0] {
        CPL_NONE     = 2'd0,
        CPL_HIT      = 2'd1,
        CPL_SPURIOUS = 2'd2
    } cpl_kind_e;

endpackage : taxi_eth_tx_tag_mgr_pkg

// File: rtl/taxi_eth_tx_tag_mgr_prio_enc.sv
// ----------------------------------------------------------------------------
// taxi_prio_enc
//
// Purpose:
//   LSB-priority encoder. It returns the index of the lowest set bit of
//   i_bits. The tag manager feeds it the inverted allocation bitmap, so the
//   result is the lowest free tag.
//
// Ports:
//   i_bits  [WIDTH-1:0] : request vector, bit 0 has the highest priority
//   o_index [IDX_W-1:0] : index of the lowest set bit (0 when none is set)
//   o_valid             : high when at least one bit of i_bits is set
// ----------------------------------------------------------------------------
module taxi_prio_enc #(
    parameter int WIDTH = 16,
    parameter int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
    input  logic [WIDTH-1:0] i_bits,
    output logic [IDX_W-1:0] o_index,
    output logic             o_valid
);

    logic [IDX_W-1:0] w_index;
    logic             w_valid;

    // The loop scans from the top bit down to bit 0. The last match it
    // writes is therefore the lowest set bit, which gives LSB priority.
    always_comb begin
        w_index = '0;
        w_valid = 1'b0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (i_bits[i]) begin
                w_index = IDX_W'(i);
                w_valid = 1'b1;
            end
        end
    end

    assign o_index = w_index;
    assign o_valid = w_valid;

endmodule : taxi_prio_enc

// File: rtl/taxi_eth_tx_tag_mgr.sv
// ----------------------------------------------------------------------------
// taxi_eth_tx_tag_mgr
//
// Purpose:
//   Manages the tags of outstanding Ethernet TX frames. The host allocates a
//   tag together with a cookie. When the MAC later reports that the frame was
//   sent, the MAC completion (tag plus timestamp) is converted into a host
//   completion that carries the stored cookie. The tag then returns to the
//   pool. A completion for a tag that is not allocated is dropped and
//   reported on err_spurious.
//
// Parameters:
//   TAG_W    : tag width, pool size N = 2**TAG_W
//   COOKIE_W : host cookie width
//   TS_W     : completion timestamp width
//
// Ports:
//   clk, rst_n                  : clock and asynchronous active-low reset
//   req_valid / req_ready       : tag allocation handshake
//   req_cookie                  : cookie stored at the granted tag
//   req_tag                     : granted tag (lowest free), valid with req_ready
//   s_cpl_valid / s_cpl_ready   : MAC completion handshake
//   s_cpl_tag, s_cpl_ts         : MAC completion tag and timestamp
//   m_cpl_valid / m_cpl_ready   : host completion handshake
//   m_cpl_cookie/_ts/_tag       : host completion payload
//   inflight                    : number of allocated tags (0..N)
//   err_spurious                : one-cycle pulse for an unallocated completion
// ----------------------------------------------------------------------------
module taxi_eth_tx_tag_mgr
    import taxi_eth_tx_tag_mgr_pkg::*;
#(
    parameter int TAG_W    = 4,
    parameter int COOKIE_W = 32,
    parameter int TS_W     = 96
) (
    input  logic                clk,
    input  logic                rst_n,

    input  logic                req_valid,
    output logic                req_ready,
    input  logic [COOKIE_W-1:0] req_cookie,
    output logic [TAG_W-1:0]    req_tag,

    input  logic                s_cpl_valid,
    output logic                s_cpl_ready,
    input  logic [TAG_W-1:0]    s_cpl_tag,
    input  logic [TS_W-1:0]     s_cpl_ts,

    output logic                m_cpl_valid,
    input  logic                m_cpl_ready,
    output logic [COOKIE_W-1:0] m_cpl_cookie,
    output logic [TS_W-1:0]     m_cpl_ts,
    output logic [TAG_W-1:0]    m_cpl_tag,

    output logic [TAG_W:0]      inflight,
    output logic                err_spurious
);

    localparam int N = 2 ** TAG_W;

    logic                r_active;
    logic [N-1:0]        r_bitmap;
    logic [N-1:0]        w_bitmap_next;
    logic [N-1:0]        w_free_bits;
    logic [TAG_W:0]      r_inflight;
    logic [COOKIE_W-1:0] r_cookie_mem [N];

    logic [TAG_W-1:0]    w_free_idx;
    logic                w_free_valid;
    logic                w_alloc;
    logic                w_cpl_fire;
    cpl_kind_e           w_cpl_kind;
    logic [COOKIE_W-1:0] w_cookie_rd;

    logic                r_m_valid;
    logic [COOKIE_W-1:0] r_m_cookie;
    logic [TS_W-1:0]     r_m_ts;
    logic [TAG_W-1:0]    r_m_tag;
    logic                r_err;

    assign w_free_bits = ~r_bitmap;

    taxi_prio_enc #(
        .WIDTH (N),
        .IDX_W (TAG_W)
    ) u_free_enc (
        .i_bits  (w_free_bits),
        .o_index (w_free_idx),
        .o_valid (w_free_valid)
    );

    // r_active is low while reset is asserted and rises on the first clock
    // edge after release. It gates both ready signals, so the block accepts
    // nothing until it has seen a clean edge out of reset.
    assign req_ready   = r_active && w_free_valid;
    assign req_tag     = w_free_idx;
    assign s_cpl_ready = r_active && (!r_m_valid || m_cpl_ready);

    assign w_alloc     = req_valid && req_ready;
    assign w_cpl_fire  = s_cpl_valid && s_cpl_ready;
    assign w_cookie_rd = r_cookie_mem[s_cpl_tag];

    // The completion is classified against the bitmap as it was before the
    // edge. A tag that is being granted in this same cycle is still clear, so
    // a completion for it is treated as spurious.
    always_comb begin
        w_cpl_kind = CPL_NONE;
        if (w_cpl_fire) begin
            w_cpl_kind = r_bitmap[s_cpl_tag] ? CPL_HIT : CPL_SPURIOUS;
        end
    end

    // An alloc and a free can never target the same bit. The granted tag is
    // clear and the freed tag is set, so the set and the clear are
    // independent.
    always_comb begin
        w_bitmap_next = r_bitmap;
        if (w_alloc) begin
            w_bitmap_next[w_free_idx] = 1'b1;
        end
        if (w_cpl_kind == CPL_HIT) begin
            w_bitmap_next[s_cpl_tag] = 1'b0;
        end
    end

    // Pool state: the bitmap, the occupancy counter and the active flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_active   <= 1'b0;
            r_bitmap   <= '0;
            r_inflight <= '0;
        end else begin
            r_active <= 1'b1;
            r_bitmap <= w_bitmap_next;
            case ({w_alloc, (w_cpl_kind == CPL_HIT)})
                2'b10:   r_inflight <= r_inflight + 1'b1;
                2'b01:   r_inflight <= r_inflight - 1'b1;
                default: r_inflight <= r_inflight;
            endcase
        end
    end

    // The cookie store has no reset and is read asynchronously, so it maps
    // onto distributed RAM. Stale cookies are harmless because a cookie is
    // only read for a tag whose bitmap bit is set.
    always_ff @(posedge clk) begin
        if (w_alloc) begin
            r_cookie_mem[w_free_idx] <= req_cookie;
        end
    end

    // Single host-completion output register. When a valid completion is
    // accepted, the register is loaded from the incoming beat and the cookie
    // store. Otherwise it holds its contents and only drops valid once the
    // host takes the beat. A new beat can only arrive when the register is
    // empty or draining, because s_cpl_ready allows nothing else.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_m_valid  <= 1'b0;
            r_m_cookie <= '0;
            r_m_ts     <= '0;
            r_m_tag    <= '0;
            r_err      <= 1'b0;
        end else begin
            r_err <= (w_cpl_kind == CPL_SPURIOUS);
            if (w_cpl_kind == CPL_HIT) begin
                r_m_valid  <= 1'b1;
                r_m_cookie <= w_cookie_rd;
                r_m_ts     <= s_cpl_ts;
                r_m_tag    <= s_cpl_tag;
            end else if (m_cpl_ready) begin
                r_m_valid <= 1'b0;
            end
        end
    end

    assign m_cpl_valid  = r_m_valid;
    assign m_cpl_cookie = r_m_cookie;
    assign m_cpl_ts     = r_m_ts;
    assign m_cpl_tag    = r_m_tag;
    assign inflight     = r_inflight;
    assign err_spurious = r_err;

endmodule : taxi_eth_tx_tag_mgr

// File: tb/tb_taxi_eth_tx_tag_mgr.sv
// ----------------------------------------------------------------------------
// tb_taxi_eth_tx_tag_mgr
//
// Testbench for the TX tag manager. A reference model of the tag pool (a
// busy-flag array, a cookie array, an occupancy count and a pending-output
// flag) predicts the response to each cycle of stimulus. Expected host
// completions go into a scoreboard queue. A monitor process samples the DUT
// on the falling clock edge and compares its outputs with the model.
// ----------------------------------------------------------------------------
module tb_taxi_eth_tx_tag_mgr;

    localparam int TAG_W    = 4;
    localparam int COOKIE_W = 32;
    localparam int TS_W     = 96;
    localparam int N        = 2 ** TAG_W;

    logic                clk;
    logic                rst_n;
    logic                req_valid;
    logic                req_ready;
    logic [COOKIE_W-1:0] req_cookie;
    logic [TAG_W-1:0]    req_tag;
    logic                s_cpl_valid;
    logic                s_cpl_ready;
    logic [TAG_W-1:0]    s_cpl_tag;
    logic [TS_W-1:0]     s_cpl_ts;
    logic                m_cpl_valid;
    logic                m_cpl_ready;
    logic [COOKIE_W-1:0] m_cpl_cookie;
    logic [TS_W-1:0]     m_cpl_ts;
    logic [TAG_W-1:0]    m_cpl_tag;
    logic [TAG_W:0]      inflight;
    logic                err_spurious;

    taxi_eth_tx_tag_mgr #(
        .TAG_W    (TAG_W),
        .COOKIE_W (COOKIE_W),
        .TS_W     (TS_W)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_cookie   (req_cookie),
        .req_tag      (req_tag),
        .s_cpl_valid  (s_cpl_valid),
        .s_cpl_ready  (s_cpl_ready),
        .s_cpl_tag    (s_cpl_tag),
        .s_cpl_ts     (s_cpl_ts),
        .m_cpl_valid  (m_cpl_valid),
        .m_cpl_ready  (m_cpl_ready),
        .m_cpl_cookie (m_cpl_cookie),
        .m_cpl_ts     (m_cpl_ts),
        .m_cpl_tag    (m_cpl_tag),
        .inflight     (inflight),
        .err_spurious (err_spurious)
    );

    typedef struct {
        logic [TAG_W-1:0]    tag;
        logic [COOKIE_W-1:0] cookie;
        logic [TS_W-1:0]     ts;
    } cplItem_t;

    cplItem_t            scoreboard[$];
    bit                  busy [N];
    logic [COOKIE_W-1:0] modelCookie [N];
    int                  modelCount;
    bit                  modelPending;
    bit                  modelErrNext;

    bit                  monEnable;
    bit                  expInReset;
    bit                  expReqReady;
    logic [TAG_W-1:0]    expReqTag;
    bit                  expSReady;
    bit                  expMValid;
    bit                  expErr;
    logic [TAG_W:0]      expInflight;

    int                  checks = 0;
    int                  errors = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog expired before the test sequence completed");
        $fatal(1);
    end

    // Each call counts one comparison. A mismatch prints a FAIL line that
    // shows the actual and the expected value.
    task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int lowestFree();
        for (int i = 0; i < N; i++) begin
            if (!busy[i]) return i;
        end
        return -1;
    endfunction

    task automatic modelReset();
        for (int i = 0; i < N; i++) busy[i] = 1'b0;
        modelCount   = 0;
        modelPending = 1'b0;
        modelErrNext = 1'b0;
        scoreboard.delete();
    endtask

    // Asserts reset for a number of cycles. The reset release comes just after
    // a rising edge, so the block must stay inactive until the following edge.
    task automatic doReset(input int cycles);
        @(posedge clk);
        #1;
        rst_n       = 1'b0;
        req_valid   = 1'b0;
        req_cookie  = '0;
        s_cpl_valid = 1'b0;
        s_cpl_tag   = '0;
        s_cpl_ts    = '0;
        m_cpl_ready = 1'b0;
        modelReset();
        expInReset  = 1'b1;
        expReqReady = 1'b0;
        expReqTag   = '0;
        expSReady   = 1'b0;
        expMValid   = 1'b0;
        expErr      = 1'b0;
        expInflight = '0;
        monEnable   = 1'b1;
        repeat (cycles) @(posedge clk);
        #1;
        rst_n      = 1'b1;
        expInReset = 1'b0;
    endtask

    // Drives one cycle of stimulus. It records what the DUT should show during
    // this cycle and then advances the reference model past the next edge.
    task automatic applyStimulus(input logic rv, input logic [COOKIE_W-1:0] ck,
                                 input logic cv, input logic [TAG_W-1:0] ctag,
                                 input logic [TS_W-1:0] ts, input logic mr);
        int  lf;
        bit  doAlloc;
        bit  doAccept;
        @(posedge clk);
        #1;
        req_valid   = rv;
        req_cookie  = ck;
        s_cpl_valid = cv;
        s_cpl_tag   = ctag;
        s_cpl_ts    = ts;
        m_cpl_ready = mr;

        lf          = lowestFree();
        expInReset  = 1'b0;
        expInflight = (TAG_W + 1)'(modelCount);
        expReqReady = (modelCount < N);
        expReqTag   = (lf >= 0) ? TAG_W'(lf) : '0;
        expSReady   = !modelPending || mr;
        expMValid   = modelPending;
        expErr      = modelErrNext;

        doAlloc  = rv && expReqReady;
        doAccept = cv && expSReady;

        if (modelPending && mr) modelPending = 1'b0;
        modelErrNext = 1'b0;
        if (doAccept) begin
            if (busy[ctag]) begin
                scoreboard.push_back('{tag: ctag, cookie: modelCookie[ctag], ts: ts});
                busy[ctag]   = 1'b0;
                modelCount   = modelCount - 1;
                modelPending = 1'b1;
            end else begin
                modelErrNext = 1'b1;
            end
        end
        if (doAlloc) begin
            busy[lf]        = 1'b1;
            modelCookie[lf] = ck;
            modelCount      = modelCount + 1;
        end
    endtask

    task automatic idleCycle(input logic mr);
        applyStimulus(1'b0, '0, 1'b0, '0, '0, mr);
    endtask

    // Monitor: compares the DUT with the model once per cycle and pops a
    // scoreboard entry each time a host completion is taken.
    always @(negedge clk) begin
        if (monEnable) begin
            checkOutput("inflight", 128'(inflight), 128'(expInflight));
            checkOutput("req_ready", 128'(req_ready), 128'(expReqReady));
            if (expReqReady) checkOutput("req_tag", 128'(req_tag), 128'(expReqTag));
            checkOutput("s_cpl_ready", 128'(s_cpl_ready), 128'(expSReady));
            checkOutput("m_cpl_valid", 128'(m_cpl_valid), 128'(expMValid));
            checkOutput("err_spurious", 128'(err_spurious), 128'(expErr));
            if (expInReset) begin
                checkOutput("rst_m_cpl_tag", 128'(m_cpl_tag), 128'(0));
                checkOutput("rst_m_cpl_cookie", 128'(m_cpl_cookie), 128'(0));
                checkOutput("rst_m_cpl_ts", 128'(m_cpl_ts), 128'(0));
            end else if (expMValid) begin
                if (scoreboard.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL sb_underflow actual=empty expected=entry at %0t", $time);
                end else begin
                    checkOutput("m_cpl_tag", 128'(m_cpl_tag), 128'(scoreboard[0].tag));
                    checkOutput("m_cpl_cookie", 128'(m_cpl_cookie), 128'(scoreboard[0].cookie));
                    checkOutput("m_cpl_ts", 128'(m_cpl_ts), 128'(scoreboard[0].ts));
                    if (m_cpl_ready) void'(scoreboard.pop_front());
                end
            end
        end
    end

    initial begin
        logic [TS_W-1:0] rts;
        rst_n       = 1'b1;
        req_valid   = 1'b0;
        req_cookie  = '0;
        s_cpl_valid = 1'b0;
        s_cpl_tag   = '0;
        s_cpl_ts    = '0;
        m_cpl_ready = 1'b0;
        monEnable   = 1'b0;
        modelReset();

        doReset(3);

        // Fill the whole pool back-to-back, then attempt one more allocation.
        for (int i = 0; i < N; i++) applyStimulus(1'b1, COOKIE_W'(32'h100 + i), 1'b0, '0, '0, 1'b1);
        applyStimulus(1'b1, 32'h200, 1'b0, '0, '0, 1'b1);
        @(negedge clk);
        checkOutput("full_inflight", 128'(inflight), 128'(16));
        checkOutput("full_req_ready", 128'(req_ready), 128'(0));

        // Complete tag 5 while the pool is full.
        applyStimulus(1'b0, '0, 1'b1, 4'd5, 96'hABC, 1'b1);
        idleCycle(1'b1);
        @(negedge clk);
        checkOutput("cpl5_valid", 128'(m_cpl_valid), 128'(1));
        checkOutput("cpl5_tag", 128'(m_cpl_tag), 128'(5));
        checkOutput("cpl5_cookie", 128'(m_cpl_cookie), 128'(32'h105));
        checkOutput("cpl5_ts", 128'(m_cpl_ts), 128'(96'hABC));
        checkOutput("cpl5_req_tag", 128'(req_tag), 128'(5));
        checkOutput("cpl5_inflight", 128'(inflight), 128'(15));

        // Free tag 3, then complete tag 3 a second time, which is spurious.
        applyStimulus(1'b0, '0, 1'b1, 4'd3, 96'h333, 1'b1);
        applyStimulus(1'b0, '0, 1'b1, 4'd3, 96'h334, 1'b1);
        idleCycle(1'b1);
        @(negedge clk);
        checkOutput("spur_err", 128'(err_spurious), 128'(1));
        checkOutput("spur_no_valid", 128'(m_cpl_valid), 128'(0));
        checkOutput("spur_inflight", 128'(inflight), 128'(14));
        idleCycle(1'b1);

        // Host back-pressure for 10 cycles with another completion waiting.
        applyStimulus(1'b0, '0, 1'b1, 4'd7, 96'h777, 1'b0);
        for (int i = 0; i < 10; i++) applyStimulus(1'b0, '0, 1'b1, 4'd8, 96'h888, 1'b0);
        @(negedge clk);
        checkOutput("stall_s_ready", 128'(s_cpl_ready), 128'(0));
        checkOutput("stall_tag", 128'(m_cpl_tag), 128'(7));
        applyStimulus(1'b0, '0, 1'b1, 4'd8, 96'h888, 1'b1);
        idleCycle(1'b0);
        @(negedge clk);
        checkOutput("release_tag", 128'(m_cpl_tag), 128'(8));
        checkOutput("release_cookie", 128'(m_cpl_cookie), 128'(32'h108));
        idleCycle(1'b1);

        // Simultaneous alloc and free of tag 0 with tags 0..3 busy.
        doReset(2);
        for (int i = 0; i < 4; i++) applyStimulus(1'b1, COOKIE_W'(32'h300 + i), 1'b0, '0, '0, 1'b1);
        applyStimulus(1'b1, 32'h3AA, 1'b1, 4'd0, 96'h35, 1'b1);
        @(negedge clk);
        checkOutput("both_req_tag", 128'(req_tag), 128'(4));
        applyStimulus(1'b1, 32'h3BB, 1'b0, '0, '0, 1'b1);
        @(negedge clk);
        checkOutput("both_inflight", 128'(inflight), 128'(4));
        checkOutput("both_next_tag", 128'(req_tag), 128'(0));
        // Completion for the tag being granted in the same cycle is spurious.
        applyStimulus(1'b1, 32'h3CC, 1'b1, 4'd5, 96'h55, 1'b1);
        idleCycle(1'b1);

        // Reset with tags outstanding and a host completion pending.
        doReset(2);
        for (int i = 0; i < 8; i++) applyStimulus(1'b1, COOKIE_W'(32'h500 + i), 1'b0, '0, '0, 1'b1);
        applyStimulus(1'b0, '0, 1'b1, 4'd2, 96'h222, 1'b0);
        idleCycle(1'b0);
        @(negedge clk);
        checkOutput("prerst_m_valid", 128'(m_cpl_valid), 128'(1));
        doReset(3);
        applyStimulus(1'b1, 32'h400, 1'b0, '0, '0, 1'b1);
        @(negedge clk);
        checkOutput("postrst_tag", 128'(req_tag), 128'(0));

        // Random traffic: first allocation-heavy, then completion-heavy.
        for (int i = 0; i < 2000; i++) begin
            rts = {$urandom(), $urandom(), $urandom()};
            if (i < 1000)
                applyStimulus(($urandom_range(0, 9) < 7), $urandom(), ($urandom_range(0, 9) < 4),
                              TAG_W'($urandom_range(0, N - 1)), rts, ($urandom_range(0, 9) < 7));
            else
                applyStimulus(($urandom_range(0, 9) < 3), $urandom(), ($urandom_range(0, 9) < 8),
                              TAG_W'($urandom_range(0, N - 1)), rts, ($urandom_range(0, 9) < 7));
        end

        for (int i = 0; i < 5; i++) idleCycle(1'b1);
        @(negedge clk);
        #1;
        checkOutput("sb_drained", 128'(scoreboard.size()), 128'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_taxi_eth_tx_tag_mgr
